// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one decoded ALU request at a time, drives the
// registered operands/opcode to an external ALU, waits for them to settle,
// samples the result and holds it until the consumer takes it.
// Optional feature: define ALU_ISSUE_SLT_FIX_EN to compute SLT results
// locally from the registered operands instead of trusting alu_z.
module alu_issue_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_aluop,
  input  logic [2:0]  req_funct3,
  input  logic        req_funct7_5,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_z,
  input  logic        alu_ex,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_zero,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] CNT_INIT = 2'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [1:0]  settle_cnt;
  logic        settle_done;
  logic [2:0]  dec_op;
  logic        dec_legal;
  logic [31:0] sample_data;

  // Translate the request class and funct fields into an ALU opcode.
  always_comb begin
    dec_op    = OP_ADD;
    dec_legal = 1'b1;
    case (req_aluop)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      default: begin
        case (req_funct3)
          3'b111: dec_op = OP_AND;
          3'b110: dec_op = OP_OR;
          3'b010: dec_op = OP_SLT;
          3'b000: dec_op = (req_aluop == 2'b10 && req_funct7_5) ? OP_SUB : OP_ADD;
          default: dec_legal = 1'b0;
        endcase
      end
    endcase
  end

  // Choose what gets captured as the response when the ALU has settled.
  always_comb begin
    sample_data = alu_z;
`ifdef ALU_ISSUE_SLT_FIX_EN
    if (alu_op == OP_SLT) begin
      sample_data = {31'b0, ($signed(alu_a) < $signed(alu_b))};
    end
`endif
  end

  assign resp_zero = (resp_data == 32'd0);

  // Issue FSM: accept in IDLE, hold operands through DRIVE, present in RESP.
  // After the settle counter reaches zero one further cycle is spent so the
  // result is captured SETTLE_CYCLES+1 edges after the accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      alu_op      <= 3'b000;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      resp_data   <= 32'd0;
      resp_err    <= 1'b0;
      settle_cnt  <= 2'd0;
      settle_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (dec_legal) begin
              alu_op      <= dec_op;
              alu_a       <= req_a;
              alu_b       <= req_b;
              settle_cnt  <= CNT_INIT;
              settle_done <= 1'b0;
              state       <= DRIVE;
            end else begin
              resp_data  <= 32'd0;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end
        end
        DRIVE: begin
          if (settle_done) begin
            resp_data   <= sample_data;
            resp_err    <= alu_ex;
            resp_valid  <= 1'b1;
            settle_done <= 1'b0;
            state       <= RESP;
          end else if (settle_cnt == 2'd0) begin
            settle_done <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 2'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: one instance with SETTLE_CYCLES=1 runs the
// decode/response vector table and the back-pressure sequence, a second
// instance with SETTLE_CYCLES=3 covers long latency and reset during DRIVE.
// Expectations for SLT follow ALU_ISSUE_SLT_FIX_EN when it is defined.
module tb_alu_issue_ctrl;

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic        ex;
    logic        legal;
    logic [2:0]  op;
    logic [31:0] data;
    logic        err;
  } vec_t;

  localparam int NV = 11;

  logic        clk;
  logic        rst1_n, rst3_n;
  logic        req_valid, resp_ready;
  logic [1:0]  req_aluop;
  logic [2:0]  req_funct3;
  logic        req_funct7_5;
  logic [31:0] req_a, req_b, alu_z;
  logic        alu_ex;

  logic        d1_req_ready, d1_resp_valid, d1_resp_zero, d1_resp_err;
  logic [2:0]  d1_alu_op;
  logic [31:0] d1_alu_a, d1_alu_b, d1_resp_data;
  logic        d3_req_ready, d3_resp_valid, d3_resp_zero, d3_resp_err;
  logic [2:0]  d3_alu_op;
  logic [31:0] d3_alu_a, d3_alu_b, d3_resp_data;

  int checks   = 0;
  int failures = 0;

  vec_t        vec [NV];
  logic [2:0]  last_op;
  logic [31:0] last_a, last_b;
  logic [31:0] slt_neg_pos, slt_pos_neg;

  alu_issue_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .req_valid(req_valid), .req_ready(d1_req_ready),
    .req_aluop(req_aluop), .req_funct3(req_funct3), .req_funct7_5(req_funct7_5),
    .req_a(req_a), .req_b(req_b), .alu_op(d1_alu_op), .alu_a(d1_alu_a),
    .alu_b(d1_alu_b), .alu_z(alu_z), .alu_ex(alu_ex), .resp_valid(d1_resp_valid),
    .resp_ready(resp_ready), .resp_data(d1_resp_data), .resp_zero(d1_resp_zero),
    .resp_err(d1_resp_err)
  );

  alu_issue_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(req_valid), .req_ready(d3_req_ready),
    .req_aluop(req_aluop), .req_funct3(req_funct3), .req_funct7_5(req_funct7_5),
    .req_a(req_a), .req_b(req_b), .alu_op(d3_alu_op), .alu_a(d3_alu_a),
    .alu_b(d3_alu_b), .alu_z(alu_z), .alu_ex(alu_ex), .resp_valid(d3_resp_valid),
    .resp_ready(resp_ready), .resp_data(d3_resp_data), .resp_zero(d3_resp_zero),
    .resp_err(d3_resp_err)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_aluop    = v.aluop;
    req_funct3   = v.f3;
    req_funct7_5 = v.f7;
    req_a        = v.a;
    req_b        = v.b;
    alu_z        = v.z;
    alu_ex       = v.ex;
    req_valid    = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkIdle3(input string tag);
    checkOutput({tag, "_req_ready"},  32'(d3_req_ready), 32'd1);
    checkOutput({tag, "_resp_valid"}, 32'(d3_resp_valid), 32'd0);
    checkOutput({tag, "_alu_op"},     32'(d3_alu_op), 32'd0);
    checkOutput({tag, "_alu_a"},      d3_alu_a, 32'd0);
    checkOutput({tag, "_alu_b"},      d3_alu_b, 32'd0);
    checkOutput({tag, "_resp_data"},  d3_resp_data, 32'd0);
    checkOutput({tag, "_resp_zero"},  32'(d3_resp_zero), 32'd1);
    checkOutput({tag, "_resp_err"},   32'(d3_resp_err), 32'd0);
  endtask

  // Issue a legal request to the SETTLE_CYCLES=3 instance and expect the
  // response exactly four edges after the accept.
  task automatic runDut3(input vec_t v, input string tag);
    applyStimulus(v);
    step();
    req_valid = 1'b0;
    checkOutput({tag, "_alu_op"}, 32'(d3_alu_op), 32'(v.op));
    for (int k = 0; k < 4; k++) begin
      checkOutput({tag, "_early_valid"}, 32'(d3_resp_valid), 32'd0);
      step();
    end
    checkOutput({tag, "_resp_valid"}, 32'(d3_resp_valid), 32'd1);
    checkOutput({tag, "_resp_data"},  d3_resp_data, v.data);
    checkOutput({tag, "_resp_err"},   32'(d3_resp_err), 32'(v.err));
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checkOutput({tag, "_back_idle"}, 32'(d3_req_ready), 32'd1);
  endtask

  initial begin
    vec_t bp;
    vec_t v3;
    rst1_n = 1'b0; rst3_n = 1'b0;
    req_valid = 1'b0; resp_ready = 1'b0;
    req_aluop = 2'b00; req_funct3 = 3'b000; req_funct7_5 = 1'b0;
    req_a = 32'd0; req_b = 32'd0; alu_z = 32'd0; alu_ex = 1'b0;

`ifdef ALU_ISSUE_SLT_FIX_EN
    slt_neg_pos = 32'd1;
    slt_pos_neg = 32'd0;
`else
    slt_neg_pos = 32'd0;
    slt_pos_neg = 32'd5;
`endif

    //           aluop  f3      f7    a              b              z              ex    legal op      data           err
    vec[0]  = '{2'b10, 3'b000, 1'b0, 32'd5,         32'd7,         32'd12,        1'b0, 1'b1, 3'b010, 32'd12,        1'b0};
    vec[1]  = '{2'b10, 3'b000, 1'b1, 32'd7,         32'd7,         32'd0,         1'b0, 1'b1, 3'b110, 32'd0,         1'b0};
    vec[2]  = '{2'b11, 3'b001, 1'b0, 32'd44,        32'd55,        32'hDEAD,      1'b0, 1'b0, 3'b000, 32'd0,         1'b1};
    vec[3]  = '{2'b10, 3'b010, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, 1'b1, 3'b111, slt_neg_pos,   1'b0};
    vec[4]  = '{2'b00, 3'b101, 1'b1, 32'd3,         32'd4,         32'd7,         1'b1, 1'b1, 3'b010, 32'd7,         1'b1};
    vec[5]  = '{2'b01, 3'b011, 1'b0, 32'd9,         32'd9,         32'd0,         1'b0, 1'b1, 3'b110, 32'd0,         1'b0};
    vec[6]  = '{2'b11, 3'b111, 1'b0, 32'h0F0F,      32'hFFFF,      32'h0F0F,      1'b0, 1'b1, 3'b000, 32'h0F0F,      1'b0};
    vec[7]  = '{2'b11, 3'b110, 1'b0, 32'hF0F0F0F0,  32'h0F0F0F0F,  32'hFFFFFFFF,  1'b0, 1'b1, 3'b001, 32'hFFFFFFFF,  1'b0};
    vec[8]  = '{2'b11, 3'b000, 1'b1, 32'd4,         32'd5,         32'd9,         1'b0, 1'b1, 3'b010, 32'd9,         1'b0};
    vec[9]  = '{2'b10, 3'b101, 1'b1, 32'd1,         32'd2,         32'd3,         1'b1, 1'b0, 3'b000, 32'd0,         1'b1};
    vec[10] = '{2'b11, 3'b010, 1'b0, 32'd1,         32'hFFFFFFFF,  32'd5,         1'b0, 1'b1, 3'b111, slt_pos_neg,   1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst1_n = 1'b1;

    checkOutput("rst_req_ready",  32'(d1_req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(d1_resp_valid), 32'd0);
    checkOutput("rst_alu_op",     32'(d1_alu_op), 32'd0);
    checkOutput("rst_alu_a",      d1_alu_a, 32'd0);
    checkOutput("rst_alu_b",      d1_alu_b, 32'd0);
    checkOutput("rst_resp_data",  d1_resp_data, 32'd0);
    checkOutput("rst_resp_zero",  32'(d1_resp_zero), 32'd1);
    checkOutput("rst_resp_err",   32'(d1_resp_err), 32'd0);

    last_op = 3'b000; last_a = 32'd0; last_b = 32'd0;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vec[i]);
      step();
      req_valid = 1'b0;
      if (vec[i].legal) begin
        checkOutput($sformatf("v%0d_req_ready", i),  32'(d1_req_ready), 32'd0);
        checkOutput($sformatf("v%0d_drive_valid", i), 32'(d1_resp_valid), 32'd0);
        checkOutput($sformatf("v%0d_alu_op", i),     32'(d1_alu_op), 32'(vec[i].op));
        checkOutput($sformatf("v%0d_alu_a", i),      d1_alu_a, vec[i].a);
        checkOutput($sformatf("v%0d_alu_b", i),      d1_alu_b, vec[i].b);
        last_op = vec[i].op; last_a = vec[i].a; last_b = vec[i].b;
        step();
        checkOutput($sformatf("v%0d_early_valid", i), 32'(d1_resp_valid), 32'd0);
        step();
      end else begin
        checkOutput($sformatf("v%0d_keep_op", i), 32'(d1_alu_op), 32'(last_op));
        checkOutput($sformatf("v%0d_keep_a", i),  d1_alu_a, last_a);
        checkOutput($sformatf("v%0d_keep_b", i),  d1_alu_b, last_b);
      end
      checkOutput($sformatf("v%0d_resp_valid", i), 32'(d1_resp_valid), 32'd1);
      checkOutput($sformatf("v%0d_resp_data", i),  d1_resp_data, vec[i].data);
      checkOutput($sformatf("v%0d_resp_zero", i),  32'(d1_resp_zero), 32'(vec[i].data == 32'd0));
      checkOutput($sformatf("v%0d_resp_err", i),   32'(d1_resp_err), 32'(vec[i].err));
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      checkOutput($sformatf("v%0d_done_valid", i), 32'(d1_resp_valid), 32'd0);
      checkOutput($sformatf("v%0d_done_ready", i), 32'(d1_req_ready), 32'd1);
    end

    // Back-pressure: response held while a new request waits at the input.
    bp = '{2'b00, 3'b000, 1'b0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b1, 3'b010, 32'd30, 1'b0};
    applyStimulus(bp);
    step();
    step();
    step();
    req_a = 32'd99; req_b = 32'd1; alu_z = 32'h77;
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_resp_valid", 32'(d1_resp_valid), 32'd1);
      checkOutput("bp_resp_data",  d1_resp_data, 32'd30);
      checkOutput("bp_req_ready",  32'(d1_req_ready), 32'd0);
      checkOutput("bp_alu_a",      d1_alu_a, 32'd10);
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checkOutput("bp_release_valid", 32'(d1_resp_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(d1_req_ready), 32'd1);
    checkOutput("bp_no_same_cycle", d1_alu_a, 32'd10);
    step();
    req_valid = 1'b0;
    checkOutput("bp_second_accept", d1_alu_a, 32'd99);
    checkOutput("bp_second_ready",  32'(d1_req_ready), 32'd0);
    step();
    step();
    checkOutput("bp_second_valid", 32'(d1_resp_valid), 32'd1);
    checkOutput("bp_second_data",  d1_resp_data, 32'h77);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Switch to the SETTLE_CYCLES=3 instance.
    rst1_n = 1'b0;
    rst3_n = 1'b1;
    checkIdle3("s3_start");

    v3 = '{2'b10, 3'b000, 1'b0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1, 3'b010, 32'd5, 1'b0};
    runDut3(v3, "s3_lat");

    // Reset while the transaction is in DRIVE discards it.
    v3 = '{2'b01, 3'b000, 1'b0, 32'd8, 32'd8, 32'h123, 1'b0, 1'b1, 3'b110, 32'h123, 1'b0};
    applyStimulus(v3);
    step();
    req_valid = 1'b0;
    rst3_n = 1'b0;
    step();
    rst3_n = 1'b1;
    checkIdle3("s3_rst");
    for (int k = 0; k < 6; k++) begin
      checkOutput("s3_rst_no_resp", 32'(d3_resp_valid), 32'd0);
      step();
    end

    v3 = '{2'b11, 3'b111, 1'b0, 32'd3, 32'd5, 32'd1, 1'b0, 1'b1, 3'b000, 32'd1, 1'b0};
    runDut3(v3, "s3_after");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, SHALL set the cycles alu_a/alu_b/alu_op are held before alu_z is sampled; legal range 1..3.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_aluop  input  2  request class: 00 load/store (add), 01 branch (sub), 10 R-type, 11 I-type.
REQ-007 req_funct3  input  3  instruction funct3.
REQ-008 req_funct7_5  input  1  instruction bit 30.
REQ-009 req_a, req_b  input  32 each  signed operands.
REQ-010 alu_op  output  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-011 alu_a, alu_b  output  32 each  registered ALU operands.
REQ-012 alu_z  input  32  ALU result; alu_ex  input  1  ALU exception flag.
REQ-013 resp_valid  output  1  response present; resp_ready  input  1  consumer accepts.
REQ-014 resp_data  output  32  result; resp_zero  output  1  resp_data == 0; resp_err  output  1  illegal decode or alu_ex.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: on req_valid=1, SHALL register decoded op, req_a, req_b onto alu_op/alu_a/alu_b and go to DRIVE with settle counter = SETTLE_CYCLES-1.
REQ-017 Decode: aluop 00 -> 010; 01 -> 110; 10/11 with funct3 111 -> 000, 110 -> 001, 010 -> 111; funct3 000 -> 010, except aluop 10 with funct7_5=1 -> 110.
REQ-018 Any other aluop 10/11 funct3 SHALL be illegal: alu_* keep previous values, FSM goes directly to RESP with resp_data=0, resp_zero=1, resp_err=1.
REQ-019 DRIVE: counter SHALL decrement each cycle; when it reads 0, alu_z and alu_ex SHALL be sampled into resp_data/resp_err and FSM goes to RESP.
REQ-020 Legal-request latency: accept at edge N, resp_valid=1 after edge N+SETTLE_CYCLES+1.
REQ-021 RESP: resp_valid=1 and resp_data/resp_zero/resp_err SHALL stay stable until a cycle with resp_ready=1, after which FSM returns to IDLE (no same-cycle new accept).
REQ-022 resp_zero SHALL be computed from the registered resp_data.
REQ-023 One transaction in flight at most; req_valid in DRIVE/RESP SHALL be ignored (req_ready=0).
REQ-024 alu_a/alu_b/alu_op SHALL not change in DRIVE or RESP.

Reset
REQ-025 When rst_n=0 at a clock edge, FSM SHALL enter IDLE; req_ready=1 and resp_valid=0 from the next cycle.
REQ-026 Reset values: alu_op=000, alu_a=0, alu_b=0, resp_data=0, resp_zero=1, resp_err=0, counter=0.
REQ-027 Reset in DRIVE or RESP SHALL discard the transaction with no response emitted.

Configuration
REQ-028 Macro ALU_ISSUE_SLT_FIX_EN: when defined, SLT ops SHALL set resp_data = {31'b0, signed(req_a) < signed(req_b)} from registered operands, ignoring alu_z (alu_ex still sampled); when undefined, resp_data SHALL equal sampled alu_z for all ops.

Verification
REQ-029 SETTLE_CYCLES=1, aluop=10, funct3=000, f7_5=0, a=5, b=7, ALU model returns 12 -> alu_op=010, resp_valid 2 edges after accept, resp_data=12, resp_zero=0, resp_err=0.
REQ-030 aluop=10, funct3=000, f7_5=1, a=7, b=7, model returns 0 -> alu_op=110, resp_data=0, resp_zero=1.
REQ-031 aluop=11, funct3=001 -> resp_valid 1 edge after accept, resp_err=1, resp_data=0, alu_op unchanged.
REQ-032 SLT a=-1 (0xFFFFFFFF), b=1, model returns 0 -> with ALU_ISSUE_SLT_FIX_EN resp_data=1; without, resp_data=0.
REQ-033 Hold resp_ready=0 for 5 cycles with req_valid=1 and new operands -> response stable, req_ready=0, no second accept until cycle after resp_ready=1.
REQ-034 SETTLE_CYCLES=3, rst_n=0 one cycle during DRIVE -> no resp_valid, all outputs at REQ-026 values, next request completes normally.
